// File: rtl/aes_seq_pkg.sv
// Shared types for the AES block sequencer: request layout and FSM states.
package aes_seq_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } seq_state_e;

    typedef struct packed {
        logic [AES_BLK_W-1:0] key;
        logic [AES_BLK_W-1:0] text;
    } aes_req_t;

endpackage

// File: rtl/aes_seq_fifo.sv
// Synchronous request FIFO; head is presented combinationally on dout_o.
module aes_seq_fifo
    import aes_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  aes_req_t               din_i,
    input  logic                   pop_i,
    output aes_req_t               dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    aes_req_t             mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage needs no reset; only entries behind count_q are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/aes_blk_sequencer.sv
// Streaming front-end for the AES core: buffers requests, issues one ld pulse
// per block, waits for done (with timeout) and holds the result for draining.
module aes_blk_sequencer
    import aes_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_key,
    input  logic [AES_BLK_W-1:0] in_text,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_text,
    output logic                 err,
    output logic                 busy,
    output logic                 aes_ld,
    output logic [AES_BLK_W-1:0] aes_key,
    output logic [AES_BLK_W-1:0] aes_text_in,
    input  logic                 aes_done,
    input  logic [AES_BLK_W-1:0] aes_text_out
);

    localparam int CW = $clog2(TIMEOUT);
    localparam int NW = $clog2(DEPTH) + 1;

    seq_state_e           state_q;
    logic [CW-1:0]        tmo_q;
    logic                 out_valid_q;
    logic [AES_BLK_W-1:0] out_text_q;
    logic                 err_q;
    logic                 aes_ld_q;
    logic [AES_BLK_W-1:0] aes_key_q;
    logic [AES_BLK_W-1:0] aes_text_q;

    aes_req_t             fifo_din;
    aes_req_t             fifo_head;
    logic [NW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    assign fifo_din = '{key: in_key, text: in_text};
    assign push     = in_valid & ~fifo_full;
    // Issue only when the result slot is free or being drained this edge,
    // so a later capture can never overwrite undrained data.
    assign pop      = (state_q == IDLE) & ~fifo_empty & (~out_valid_q | out_ready);

    aes_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_text_q  <= '0;
            err_q       <= 1'b0;
            aes_ld_q    <= 1'b0;
            aes_key_q   <= '0;
            aes_text_q  <= '0;
        end else begin
            aes_ld_q <= 1'b0;
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        aes_key_q  <= fifo_head.key;
                        aes_text_q <= fifo_head.text;
                        aes_ld_q   <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (aes_done) begin
                        out_text_q  <= aes_text_out;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (fifo_count != NW'(DEPTH));
    assign out_valid   = out_valid_q;
    assign out_text    = out_text_q;
    assign err         = err_q;
    assign busy        = ~fifo_empty | (state_q != IDLE) | out_valid_q;
    assign aes_ld      = aes_ld_q;
    assign aes_key     = aes_key_q;
    assign aes_text_in = aes_text_q;

endmodule

// File: tb/tb_aes_blk_sequencer.sv
// Directed bench for aes_blk_sequencer with a small behavioural AES core model.
module tb_aes_blk_sequencer;
    import aes_seq_pkg::*;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_key = '0;
    logic [127:0] in_text = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_text;
    logic         err;
    logic         busy;
    logic         aes_ld;
    logic [127:0] aes_key;
    logic [127:0] aes_text_in;
    logic         aes_done;
    logic [127:0] aes_text_out;

    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;

    aes_blk_sequencer #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_key       (in_key),
        .in_text      (in_text),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_text     (out_text),
        .err          (err),
        .busy         (busy),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text_in  (aes_text_in),
        .aes_done     (aes_done),
        .aes_text_out (aes_text_out)
    );

    always #5 clk = ~clk;

    // Core model: known FIPS-197 vector, otherwise ~(key ^ text); done 3 cycles after ld.
    function automatic logic [127:0] ct(input logic [127:0] k, input logic [127:0] t);
        if (k == KEY0 && t == PT0) return CT0;
        return ~(k ^ t);
    endfunction

    function automatic logic [127:0] rk(input int i);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(i);
        return {4{w}};
    endfunction

    function automatic logic [127:0] rt(input int i);
        logic [31:0] w;
        w = 32'h1357_0000 + 32'(i * 17);
        return {w, ~w, w ^ 32'h0F0F_0F0F, 32'(i)};
    endfunction

    logic         hang = 1'b0;
    logic         spur = 1'b0;
    logic         m_done = 1'b0;
    logic         m_busy = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_k = '0;
    logic [127:0] m_t = '0;
    logic [127:0] m_out = '0;

    assign aes_done     = m_done | spur;
    assign aes_text_out = m_out;

    always @(posedge clk) begin
        if (rst) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (aes_ld && !hang) begin
                m_busy <= 1'b1;
                m_cnt  <= 3;
                m_k    <= aes_key;
                m_t    <= aes_text_in;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_out  <= ct(m_k, m_t);
                    m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) if (!rst && aes_ld) ld_cnt++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [127:0] k, input logic [127:0] t);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_key   = k;
        in_text  = t;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("push_timeout", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int bound, output int n);
        n = 0;
        while (!out_valid && n < bound) begin
            tick();
            n++;
        end
        if (!out_valid) chk("wait_out_timeout", 128'(out_valid), 128'(1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int got;

        // Reset state
        repeat (2) tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_aes_ld", 128'(aes_ld), 128'(0));
        chk("rst_aes_key", aes_key, 128'(0));
        chk("rst_out_text", out_text, 128'(0));
        rst = 1'b0;
        tick();

        // Single request with the FIPS-197 vector
        base = ld_cnt;
        push(KEY0, PT0);
        chk("single_busy", 128'(busy), 128'(1));
        chk("single_ld_early", 128'(aes_ld), 128'(0));
        tick();
        chk("single_ld", 128'(aes_ld), 128'(1));
        chk("single_key", aes_key, KEY0);
        chk("single_text_in", aes_text_in, PT0);
        tick();
        chk("single_ld_off", 128'(aes_ld), 128'(0));
        chk("single_key_hold", aes_key, KEY0);
        wait_out(20, n);
        chk("single_latency", 128'(n), 128'(4));
        chk("single_ct", out_text, CT0);
        chk("single_err", 128'(err), 128'(0));
        chk("single_ld_count", 128'(ld_cnt - base), 128'(1));
        drain();
        chk("single_drained", 128'(out_valid), 128'(0));
        chk("single_idle", 128'(busy), 128'(0));

        // FIFO fill under backpressure, then in-order drain
        base = ld_cnt;
        for (int i = 0; i < 5; i++) push(rk(i), rt(i));
        chk("fill_in_ready_low", 128'(in_ready), 128'(0));
        wait_out(20, n);
        chk("fill_r0", out_text, ct(rk(0), rt(0)));
        repeat (5) tick();
        chk("bp_no_second_ld", 128'(ld_cnt - base), 128'(1));
        chk("bp_hold_valid", 128'(out_valid), 128'(1));
        chk("bp_hold_text", out_text, ct(rk(0), rt(0)));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_out(20, n);
                chk("fill_order", out_text, ct(rk(i), rt(i)));
            end
            drain();
            if (i == 0) begin
                chk("fill_in_ready_back", 128'(in_ready), 128'(1));
                chk("fill_drain_clears", 128'(out_valid), 128'(0));
            end
        end
        chk("fill_ld_count", 128'(ld_cnt - base), 128'(5));

        // Streaming with out_ready held high
        base = ld_cnt;
        out_ready = 1'b1;
        for (int i = 5; i < 8; i++) push(rk(i), rt(i));
        got = 0;
        for (int c = 0; c < 80 && got < 3; c++) begin
            if (out_valid) begin
                chk("stream_order", out_text, ct(rk(5 + got), rt(5 + got)));
                got++;
            end
            tick();
        end
        chk("stream_count", 128'(got), 128'(3));
        chk("stream_ld_count", 128'(ld_cnt - base), 128'(3));
        out_ready = 1'b0;

        // Timeout: core never answers
        hang = 1'b1;
        push(rk(20), rt(20));
        repeat (5) tick();
        chk("tmo_key_hold", aes_key, rk(20));
        repeat (4) tick();
        chk("tmo_err_not_yet", 128'(err), 128'(0));
        chk("tmo_busy_wait", 128'(busy), 128'(1));
        tick();
        chk("tmo_err_set", 128'(err), 128'(1));
        chk("tmo_idle", 128'(busy), 128'(0));
        chk("tmo_no_valid", 128'(out_valid), 128'(0));
        hang = 1'b0;
        push(rk(21), rt(21));
        wait_out(20, n);
        chk("tmo_next_ok", out_text, ct(rk(21), rt(21)));
        chk("tmo_err_sticky", 128'(err), 128'(1));
        drain();

        // Spurious done in IDLE and in LOAD
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        chk("spur_idle_valid", 128'(out_valid), 128'(0));
        hang = 1'b1;
        push(rk(30), rt(30));
        tick();
        chk("spur_load_ld", 128'(aes_ld), 128'(1));
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_load_valid", 128'(out_valid), 128'(0));

        // Reset mid-WAIT with two requests queued
        push(rk(31), rt(31));
        push(rk(32), rt(32));
        chk("mid_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        chk("mid_in_ready", 128'(in_ready), 128'(1));
        chk("mid_busy_clr", 128'(busy), 128'(0));
        chk("mid_err_clr", 128'(err), 128'(0));
        chk("mid_aes_ld", 128'(aes_ld), 128'(0));
        chk("mid_aes_key", aes_key, 128'(0));
        chk("mid_aes_text", aes_text_in, 128'(0));
        chk("mid_out_text", out_text, 128'(0));
        rst = 1'b0;
        hang = 1'b0;
        base = ld_cnt;
        out_ready = 1'b0;
        repeat (20) tick();
        chk("mid_no_valid", 128'(out_valid), 128'(0));
        chk("mid_no_ld", 128'(ld_cnt - base), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
